// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS32 pipeline definitions.
//   REG_ADDR_W  GPR address width
//   REG_ZERO    address of the hard-wired zero register
//   ld_size_t   load size encoding (2'b11 is reserved and handled as a word)
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10
  } ld_size_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: combinational sub-word load extraction.
// Selects the little-endian byte/half lane from an aligned data word,
// sign- or zero-extends it and flags misaligned half/word accesses.
//   word_i      aligned word from data memory
//   addr_lsb_i  effective address bits [1:0]
//   size_i      load size (ld_size_t encoding)
//   unsigned_i  zero-extend instead of sign-extend
//   data_o      extended load data
//   misalign_o  access is misaligned for its size
module load_align
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [1:0]            addr_lsb_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        byte_ext;
  logic        half_ext;

  always_comb begin
    byte_sel = word_i[{addr_lsb_i, 3'b000} +: 8];
    half_sel = addr_lsb_i[1] ? word_i[31:16] : word_i[15:0];
    byte_ext = byte_sel[7] & ~unsigned_i;
    half_ext = half_sel[15] & ~unsigned_i;

    data_o     = word_i;
    misalign_o = 1'b0;
    case (ld_size_t'(size_i))
      LD_BYTE: begin
        data_o = {{(DATA_WIDTH-8){byte_ext}}, byte_sel};
      end
      LD_HALF: begin
        data_o     = {{(DATA_WIDTH-16){half_ext}}, half_sel};
        misalign_o = addr_lsb_i[0];
      end
      // LD_WORD and the reserved encoding both load the full word
      default: begin
        data_o     = word_i;
        misalign_o = |addr_lsb_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS32 memory-to-writeback pipeline register.
// Captures the retiring instruction (load data already extracted), drives the
// register file write port and an identical forwarding copy, suppresses
// writes to $0 and misaligned loads, and pulses misalign_err once per
// misaligned load.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   MEM handshake (in_ready = !stall)
//   stall, flush          hazard unit hold / kill
//   in_*                  instruction fields from the MEM stage
//   wr_en/wr_addr/wr_data register file write port
//   fwd_*                 forwarding copy of the write port
//   misalign_err          one-cycle misaligned-load pulse
// Optional macro RETIRE_CNT_EN adds output retire_count[31:0], a wrapping
// count of instructions that occupied the stage.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_reg_wr,
  input  logic                  in_mem_to_reg,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [REG_ADDR_W-1:0] in_wr_addr,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
`ifdef RETIRE_CNT_EN
  output logic                  misalign_err,
  output logic [31:0]           retire_count
`else
  output logic                  misalign_err
`endif
);

  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  reg_wr_q, reg_wr_d;
  logic                  misalign_q, misalign_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_misalign;
  logic                  first_cycle;

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .word_i     (in_mem_rdata),
    .addr_lsb_i (in_alu_result[1:0]),
    .size_i     (in_ld_size),
    .unsigned_i (in_ld_unsigned),
    .data_o     (ld_data),
    .misalign_o (ld_misalign)
  );

  assign in_ready = !stall;

  always_comb begin
    valid_d    = valid_q;
    done_d     = done_q;
    reg_wr_d   = reg_wr_q;
    misalign_d = misalign_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall) begin
      // a held entry has already had its one write cycle
      done_d = valid_q;
    end else begin
      valid_d = in_valid;
      done_d  = 1'b0;
      if (in_valid) begin
        reg_wr_d   = in_reg_wr;
        misalign_d = in_mem_to_reg & ld_misalign;
        wr_addr_d  = in_wr_addr;
        wr_data_d  = in_mem_to_reg ? ld_data : in_alu_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      reg_wr_q   <= 1'b0;
      misalign_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      done_q     <= done_d;
      reg_wr_q   <= reg_wr_d;
      misalign_q <= misalign_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign first_cycle  = valid_q & !done_q;
  assign wr_en        = first_cycle & reg_wr_q & (wr_addr_q != REG_ZERO) & !misalign_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign fwd_valid    = wr_en;
  assign fwd_addr     = wr_addr_q;
  assign fwd_data     = wr_data_q;
  assign misalign_err = first_cycle & misalign_q;

`ifdef RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // $0 and misaligned entries still count as retired
  assign retire_cnt_d = retire_cnt_q + {31'd0, first_cycle};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed plus randomized bench for mem_wb_stage.
// A behavioural model tracks the entry in the stage and how long it has been
// there; load extraction is computed with shifts and masks.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_reg_wr = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic [1:0]  in_ld_size = 2'b10;
  logic        in_ld_unsigned = 1'b0;
  logic [4:0]  in_wr_addr = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic [31:0] in_mem_rdata = 32'd0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        misalign_err;
`ifdef RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .stall          (stall),
    .flush          (flush),
    .in_reg_wr      (in_reg_wr),
    .in_mem_to_reg  (in_mem_to_reg),
    .in_ld_size     (in_ld_size),
    .in_ld_unsigned (in_ld_unsigned),
    .in_wr_addr     (in_wr_addr),
    .in_alu_result  (in_alu_result),
    .in_mem_rdata   (in_mem_rdata),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .fwd_valid      (fwd_valid),
    .fwd_addr       (fwd_addr),
    .fwd_data       (fwd_data),
`ifdef RETIRE_CNT_EN
    .misalign_err   (misalign_err),
    .retire_count   (retire_count)
`else
    .misalign_err   (misalign_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model of the entry held in the stage
  bit          m_valid = 1'b0;
  int          m_age   = 0;
  bit          m_reg_wr = 1'b0;
  bit          m_mis   = 1'b0;
  logic [4:0]  m_addr  = 5'd0;
  logic [31:0] m_data  = 32'd0;
  logic [31:0] m_cnt   = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_load(input bit m2r, input int unsigned sz, input bit uns,
                                   input logic [31:0] alu, input logic [31:0] rd,
                                   output logic [31:0] d, output bit mis);
    int unsigned lane;
    logic [31:0] v;
    if (!m2r) begin
      d = alu; mis = 1'b0;
    end else if (sz == 0) begin
      lane = alu % 4;
      v = (rd >> (8 * lane)) & 32'hFF;
      if (!uns && v >= 128) v = v - 32'd256;
      d = v; mis = 1'b0;
    end else if (sz == 1) begin
      lane = (alu / 2) % 2;
      v = (rd >> (16 * lane)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 32'd65536;
      d = v; mis = (alu % 2) != 0;
    end else begin
      d = rd; mis = (alu % 4) != 0;
    end
  endfunction

  task automatic model_edge();
    if (m_valid && m_age == 0) m_cnt = m_cnt + 1;
    if (flush) begin
      m_valid = 1'b0;
    end else if (stall) begin
      if (m_valid) m_age++;
    end else if (in_valid) begin
      m_valid  = 1'b1;
      m_age    = 0;
      m_reg_wr = in_reg_wr;
      m_addr   = in_wr_addr;
      ref_load(in_mem_to_reg, in_ld_size, in_ld_unsigned, in_alu_result, in_mem_rdata, m_data, m_mis);
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    bit exp_en;
    bit exp_mis;
    exp_en  = m_valid && m_age == 0 && m_reg_wr && m_addr != 5'd0 && !m_mis;
    exp_mis = m_valid && m_age == 0 && m_mis;
    check("wr_en", {31'd0, wr_en}, {31'd0, exp_en});
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, exp_en});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
    check("in_ready", {31'd0, in_ready}, {31'd0, !stall});
    if (exp_en) begin
      check("wr_addr", {27'd0, wr_addr}, {27'd0, m_addr});
      check("wr_data", wr_data, m_data);
      check("fwd_addr", {27'd0, fwd_addr}, {27'd0, m_addr});
      check("fwd_data", fwd_data, m_data);
    end
`ifdef RETIRE_CNT_EN
    check("retire_count", retire_count, m_cnt);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic set_in(input bit v, input bit rw, input bit m2r, input logic [1:0] sz,
                        input bit uns, input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] rd);
    in_valid = v; in_reg_wr = rw; in_mem_to_reg = m2r; in_ld_size = sz;
    in_ld_unsigned = uns; in_wr_addr = wa; in_alu_result = alu; in_mem_rdata = rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {27'd0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    check({tag, "_fwd_addr"}, {27'd0, fwd_addr}, 32'd0);
    check({tag, "_fwd_data"}, fwd_data, 32'd0);
    check({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
`ifdef RETIRE_CNT_EN
    check({tag, "_retire"}, retire_count, 32'd0);
`endif
  endtask

  initial begin
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // word load
    set_in(1, 1, 1, 2'b10, 0, 5'd8, 32'h100, 32'hDEADBEEF);
    tick();
    check("word_data", wr_data, 32'hDEADBEEF);
    check("word_addr", {27'd0, wr_addr}, 32'd8);
    // byte loads, signed then unsigned
    set_in(1, 1, 1, 2'b00, 0, 5'd9, 32'h103, 32'h80112233);
    tick();
    check("byte_signed", wr_data, 32'hFFFFFF80);
    set_in(1, 1, 1, 2'b00, 1, 5'd9, 32'h103, 32'h80112233);
    tick();
    check("byte_unsigned", wr_data, 32'h00000080);
    // misaligned half then aligned half
    set_in(1, 1, 1, 2'b01, 0, 5'd10, 32'h101, 32'h7FFF0000);
    tick();
    check("half_mis_pulse", {31'd0, misalign_err}, 32'd1);
    set_in(1, 1, 1, 2'b01, 0, 5'd10, 32'h102, 32'h7FFF0000);
    tick();
    check("half_aligned", wr_data, 32'h00007FFF);
    // ALU writeback to $0
    set_in(1, 1, 0, 2'b10, 0, 5'd0, 32'd5, 32'd0);
    tick();
    check("zero_reg_no_write", {31'd0, wr_en}, 32'd0);
    in_valid = 0;
    tick();
    // stall held for 3 cycles on an entry
    set_in(1, 1, 0, 2'b10, 0, 5'd12, 32'h55, 32'd0);
    tick();
    stall = 1;
    in_wr_addr = 5'd13;
    for (int i = 0; i < 3; i++) tick();
    stall = 0;
    in_valid = 0;
    tick();
    // flush kills the incoming instruction
    set_in(1, 1, 0, 2'b10, 0, 5'd13, 32'h77, 32'd0);
    flush = 1;
    tick();
    check("flush_no_write", {31'd0, wr_en}, 32'd0);
    flush = 0;
    in_valid = 0;
    tick();
    // asynchronous reset mid-stall
    set_in(1, 1, 0, 2'b10, 0, 5'd14, 32'h99, 32'd0);
    tick();
    stall = 1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_valid = 0; m_age = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stall = 0;
    in_valid = 0;
    tick();
    check("post_rst_no_write", {31'd0, wr_en}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             2'($urandom_range(0, 3)), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
             $urandom, $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
